// File: rtl/uni_shift_pkg.sv
// Shared definitions for the universal shift register serializer/deserializer pair.
package uni_shift_pkg;

  // Shift-register control encoding, common to both ends of the link.
  typedef enum logic [1:0] {
    HOLD = 2'b00,
    SHL  = 2'b01,
    SHR  = 2'b10,
    LOAD = 2'b11
  } shift_ctrl_e;

  // Receiver word-assembly state.
  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } deser_state_e;

endpackage

// File: rtl/deser_bit_counter.sv
// Modulo-N bit counter for the deserializer: clr realigns, inc counts a sampled bit.
module deser_bit_counter #(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clr,
  input  logic                 inc,
  output logic [$clog2(N)-1:0] bit_cnt,
  output logic                 last_bit
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: a clear with a sampled bit starts a new word already holding one bit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr && inc)      cnt_d = CW'(1);
    else if (clr)        cnt_d = '0;
    else if (inc)        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
  end

  // Count register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign bit_cnt  = cnt_q;
  assign last_bit = (cnt_q == LAST);

endmodule

// File: rtl/uni_shift_deser.sv
// Serial-in/parallel-out word receiver with a valid/ready output and sticky overrun.
module uni_shift_deser
  import uni_shift_pkg::*;
#(
  parameter int N         = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 sync,
  input  logic                 bit_en,
  input  logic                 serial_in,
  input  logic                 out_ready,
  input  logic                 ovr_clr,
  output logic [N-1:0]         data_out,
  output logic                 out_valid,
  output logic                 overrun,
  output logic [$clog2(N)-1:0] bit_cnt
);

  logic [N-1:0] shreg_q, shreg_d, shreg_base;
  logic [N-1:0] data_q, data_d;
  logic         valid_q, valid_d;
  logic         ovr_q, ovr_d;
  deser_state_e state_q, state_d;
  shift_ctrl_e  op;
  logic         last_bit, complete, load, drop;

  deser_bit_counter #(.N(N)) u_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (sync),
    .inc      (bit_en),
    .bit_cnt  (bit_cnt),
    .last_bit (last_bit)
  );

  // Shift path: sync drops the partial word before the new bit (if any) enters.
  always_comb begin
    op = HOLD;
    if (bit_en) op = (MSB_FIRST != 0) ? SHL : SHR;
    shreg_base = sync ? '0 : shreg_q;
    case (op)
      SHL:     shreg_d = {shreg_base[N-2:0], serial_in};
      SHR:     shreg_d = {serial_in, shreg_base[N-1:1]};
      default: shreg_d = shreg_base;
    endcase
  end

  // Word boundary tracking; a sync'd bit always starts a fresh word.
  always_comb begin
    state_d = state_q;
    if (sync)        state_d = bit_en ? RECV : IDLE;
    else if (bit_en) state_d = last_bit ? IDLE : RECV;
  end

  // Handshake: a completed word loads if the slot is free or draining this cycle.
  always_comb begin
    complete = bit_en && !sync && last_bit && (state_q == RECV);
    load     = complete && (!valid_q || out_ready);
    drop     = complete && valid_q && !out_ready;
    data_d   = data_q;
    valid_d  = valid_q;
    ovr_d    = ovr_q;
    if (valid_q && out_ready) valid_d = 1'b0;
    if (load) begin
      data_d  = shreg_d;
      valid_d = 1'b1;
    end
    if (ovr_clr) ovr_d = 1'b0;
    if (drop)    ovr_d = 1'b1;
  end

  // Datapath and control registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      state_q <= IDLE;
    end else begin
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      state_q <= state_d;
    end
  end

  assign data_out  = data_q;
  assign out_valid = valid_q;
  assign overrun   = ovr_q;

endmodule
